// File: rtl/mm_tile_feeder_pkg.sv
// Shared definitions for the mm_unit tile feeder.
//   tile_count : derived tile count along one dimension (dim / tile size)
//   VLD, LASTK : bit positions inside the in_valid word
//   state_t    : sweep FSM encoding
package mm_tile_feeder_pkg;

    function automatic int tile_count(input int dim, input int tile);
        return dim / tile;
    endfunction

    localparam int VLD   = 0;
    localparam int LASTK = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mm_tile_counter.sv
// Three-level nested wrap counter walking (mt, nt, kt) with kt innermost.
//   clk, reset : clock, synchronous active-high reset
//   clr        : synchronous clear to (0,0,0)
//   adv        : step one tile position
//   mt, nt, kt : current tile indices
//   last       : all three indices at their maxima
//   last_k     : kt at its maximum
module mm_tile_counter #(
    parameter int MT_N = 4,
    parameter int NT_N = 4,
    parameter int KT_N = 4,
    parameter int CW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          adv,
    output logic [CW-1:0] mt,
    output logic [CW-1:0] nt,
    output logic [CW-1:0] kt,
    output logic          last,
    output logic          last_k
);

    localparam logic [CW-1:0] MT_MAX = CW'(MT_N - 1);
    localparam logic [CW-1:0] NT_MAX = CW'(NT_N - 1);
    localparam logic [CW-1:0] KT_MAX = CW'(KT_N - 1);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            mt <= '0;
            nt <= '0;
            kt <= '0;
        end else if (adv) begin
            if (kt == KT_MAX) begin
                kt <= '0;
                if (nt == NT_MAX) begin
                    nt <= '0;
                    mt <= (mt == MT_MAX) ? '0 : mt + 1'b1;
                end else begin
                    nt <= nt + 1'b1;
                end
            end else begin
                kt <= kt + 1'b1;
            end
        end
    end

    assign last_k = (kt == KT_MAX);
    assign last   = last_k && (nt == NT_MAX) && (mt == MT_MAX);

endmodule

// File: rtl/mm_tile_feeder.sv
// Transmit side of the mm_unit tile interface. Holds one A (MxK) and one
// B (KxN) int8 matrix, loaded row by row while idle, and on start streams
// every (mt, nt, kt) tile as a registered packed word.
//   clk, reset, enable : clock, sync active-high reset, global advance
//   a_we/a_row/a_data  : A row write (idle only, out-of-range ignored)
//   b_we/b_row/b_data  : B row write (idle only, out-of-range ignored)
//   start              : begin a tile sweep
//   busy, done         : sweep in progress / one-cycle completion pulse
//   ptr_m, ptr_n       : tile indices of the current word
//   in_a, in_b         : packed A and B tiles
//   in_valid           : [VLD] word valid, [LASTK] last k-tile
module mm_tile_feeder
    import mm_tile_feeder_pkg::*;
#(
    parameter int M            = 16,
    parameter int K            = 16,
    parameter int N            = 16,
    parameter int N_GROUP      = 4,
    parameter int N_MUL        = 4,
    parameter int N_UNIT       = 4,
    parameter int DW_MUL       = 8,
    parameter int DW_INT       = 8,
    parameter int DW_CORE_IN_A = DW_MUL * N_MUL * N_GROUP,
    parameter int DW_CORE_IN_B = DW_MUL * N_MUL * N_UNIT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           a_we,
    input  logic [DW_INT-1:0]              a_row,
    input  logic [DW_MUL*K-1:0]            a_data,
    input  logic                           b_we,
    input  logic [DW_INT-1:0]              b_row,
    input  logic [DW_MUL*N-1:0]            b_data,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic [DW_INT-1:0]              ptr_m,
    output logic [DW_INT-1:0]              ptr_n,
    output logic signed [DW_CORE_IN_A-1:0] in_a,
    output logic signed [DW_CORE_IN_B-1:0] in_b,
    output logic [1:0]                     in_valid
);

    localparam int MT_N = tile_count(M, N_GROUP);
    localparam int NT_N = tile_count(N, N_UNIT);
    localparam int KT_N = tile_count(K, N_MUL);
    localparam int AW   = (M > 1) ? $clog2(M) : 1;
    localparam int KW   = (K > 1) ? $clog2(K) : 1;
    localparam int NW   = (N > 1) ? $clog2(N) : 1;

    div_check: assert property (@(posedge clk)
        (M % N_GROUP == 0) && (K % N_MUL == 0) && (N % N_UNIT == 0));

    // Matrix stores, element-addressed [row][col][bit].
    logic [M-1:0][K-1:0][DW_MUL-1:0] a_mem;
    logic [K-1:0][N-1:0][DW_MUL-1:0] b_mem;

    state_t state, state_nxt;
    logic   cnt_clr, cnt_adv, load_ok;
    logic   cnt_last, cnt_last_k;
    logic [DW_INT-1:0] mt, nt, kt;

    mm_tile_counter #(
        .MT_N (MT_N),
        .NT_N (NT_N),
        .KT_N (KT_N),
        .CW   (DW_INT)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .adv    (cnt_adv),
        .mt     (mt),
        .nt     (nt),
        .kt     (kt),
        .last   (cnt_last),
        .last_k (cnt_last_k)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else if (enable)
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (cnt_last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM: control decode
    always_comb begin
        cnt_clr = 1'b0;
        cnt_adv = 1'b0;
        load_ok = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_clr = enable && start;
                load_ok = enable;
            end
            ST_RUN:  cnt_adv = enable;
            default: ;
        endcase
    end

    // Row loads; both stores may be written in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_mem <= '0;
            b_mem <= '0;
        end else if (load_ok) begin
            if (a_we && (int'(a_row) < M))
                a_mem[a_row[AW-1:0]] <= a_data;
            if (b_we && (int'(b_row) < K))
                b_mem[b_row[KW-1:0]] <= b_data;
        end
    end

    // Tile gather. Lane (g,j) of A is A[mt*N_GROUP+g][kt*N_MUL+j];
    // lane (u,j) of B is B[kt*N_MUL+j][nt*N_UNIT+u].
    logic [N_GROUP-1:0][N_MUL-1:0][DW_MUL-1:0] a_tile;
    logic [N_UNIT-1:0][N_MUL-1:0][DW_MUL-1:0]  b_tile;

    for (genvar g = 0; g < N_GROUP; g++) begin : g_a_grp
        for (genvar j = 0; j < N_MUL; j++) begin : g_a_mul
            assign a_tile[g][j] = a_mem[AW'(int'(mt) * N_GROUP + g)]
                                       [KW'(int'(kt) * N_MUL + j)];
        end
    end

    for (genvar u = 0; u < N_UNIT; u++) begin : g_b_unit
        for (genvar j = 0; j < N_MUL; j++) begin : g_b_mul
            assign b_tile[u][j] = b_mem[KW'(int'(kt) * N_MUL + j)]
                                       [NW'(int'(nt) * N_UNIT + u)];
        end
    end

    // Output word register. busy covers the cycle after start through the
    // last word; done follows one enabled cycle later. Tile data holds
    // outside RUN so only in_valid marks it stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            ptr_m    <= '0;
            ptr_n    <= '0;
            in_a     <= '0;
            in_b     <= '0;
            in_valid <= '0;
        end else if (enable) begin
            busy     <= (state == ST_RUN) || ((state == ST_IDLE) && start);
            done     <= (state == ST_DONE);
            in_valid <= '0;
            if (state == ST_RUN) begin
                ptr_m           <= mt;
                ptr_n           <= nt;
                in_a            <= a_tile;
                in_b            <= b_tile;
                in_valid[VLD]   <= 1'b1;
                in_valid[LASTK] <= cnt_last_k;
            end
        end
    end

endmodule

// File: tb/tb_mm_tile_feeder.sv
module tb_mm_tile_feeder;

    localparam int M = 16, K = 16, N = 16;
    localparam int NG = 4, NM = 4, NU = 4;
    localparam int DW = 8, DI = 8;
    localparam int DA = DW * NM * NG;
    localparam int DB = DW * NM * NU;
    localparam int WORDS = (M / NG) * (N / NU) * (K / NM);
    localparam int KTILES = K / NM;

    logic clk = 1'b0;
    logic reset, enable, a_we, b_we, start;
    logic [DI-1:0]   a_row, b_row;
    logic [DW*K-1:0] a_data;
    logic [DW*N-1:0] b_data;
    logic            busy, done;
    logic [DI-1:0]   ptr_m, ptr_n;
    logic [DA-1:0]   in_a;
    logic [DB-1:0]   in_b;
    logic [1:0]      in_valid;

    always #5 clk = ~clk;

    mm_tile_feeder #(
        .M(M), .K(K), .N(N), .N_GROUP(NG), .N_MUL(NM), .N_UNIT(NU),
        .DW_MUL(DW), .DW_INT(DI), .DW_CORE_IN_A(DA), .DW_CORE_IN_B(DB)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .a_we(a_we), .a_row(a_row), .a_data(a_data),
        .b_we(b_we), .b_row(b_row), .b_data(b_data),
        .start(start), .busy(busy), .done(done),
        .ptr_m(ptr_m), .ptr_n(ptr_n), .in_a(in_a), .in_b(in_b),
        .in_valid(in_valid)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference matrices and expected tile stream.
    logic [7:0] ma [M][K];
    logic [7:0] mb [K][N];

    typedef struct {
        logic [DA-1:0] a;
        logic [DB-1:0] b;
        int            pm;
        int            pn;
        bit            lk;
    } word_t;

    word_t exp_q[$];

    logic [DA-1:0] first_a, last_a;
    logic [DB-1:0] first_b;
    logic [DI-1:0] first_pm, first_pn, last_pm, last_pn;
    logic [1:0]    first_v;

    function automatic void build_exp();
        word_t e;
        exp_q.delete();
        for (int mt = 0; mt < M / NG; mt++)
            for (int nt = 0; nt < N / NU; nt++)
                for (int kt = 0; kt < KTILES; kt++) begin
                    e.a = '0;
                    e.b = '0;
                    for (int g = 0; g < NG; g++)
                        for (int j = 0; j < NM; j++)
                            e.a[(g*NM+j)*DW +: DW] = ma[mt*NG+g][kt*NM+j];
                    for (int u = 0; u < NU; u++)
                        for (int j = 0; j < NM; j++)
                            e.b[(u*NM+j)*DW +: DW] = mb[kt*NM+j][nt*NU+u];
                    e.pm = mt;
                    e.pn = nt;
                    e.lk = (kt == KTILES - 1);
                    exp_q.push_back(e);
                end
    endfunction

    task automatic tick(input bit en);
        enable = en;
        @(posedge clk);
        #1;
    endtask

    task automatic load_all();
        for (int i = 0; i < M || i < K; i++) begin
            a_we  = (i < M);
            b_we  = (i < K);
            a_row = DI'(i);
            b_row = DI'(i);
            for (int k = 0; k < K; k++) a_data[k*DW +: DW] = (i < M) ? ma[i][k] : 8'h00;
            for (int n = 0; n < N; n++) b_data[n*DW +: DW] = (i < K) ? mb[i][n] : 8'h00;
            tick(1);
        end
        // out-of-range rows must leave both stores untouched
        a_we   = 1'b1;
        b_we   = 1'b1;
        a_row  = DI'(M + $urandom_range(0, 3));
        b_row  = DI'(K + $urandom_range(0, 3));
        a_data = {$urandom, $urandom, $urandom, $urandom};
        b_data = {$urandom, $urandom, $urandom, $urandom};
        tick(1);
        a_we = 1'b0;
        b_we = 1'b0;
    endtask

    task automatic run_sweep(input string nm, input int rnd_pct, input int stall_at, input bit poke);
        word_t e;
        logic [319:0] snap;
        int  words = 0, lk_cnt = 0, cyc = 0, stall_left = 0;
        bit  fin = 1'b0, en;
        build_exp();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check({nm, ":busy_start"}, busy, 1);
        check({nm, ":vld_start"}, in_valid, 0);
        while (!fin && cyc < 1000) begin
            cyc++;
            en = 1'b1;
            if (rnd_pct > 0 && $urandom_range(0, 99) < rnd_pct) en = 1'b0;
            if (stall_left > 0) begin
                en = 1'b0;
                stall_left--;
            end
            if (poke && words == 5) begin
                a_we   = 1'b1;
                a_row  = DI'($urandom_range(0, M - 1));
                a_data = '1;
                start  = 1'b1;
            end
            snap = {busy, done, in_valid, ptr_m, ptr_n, in_a, in_b};
            tick(en);
            a_we  = 1'b0;
            start = 1'b0;
            if (!en) begin
                check({nm, ":hold"}, {busy, done, in_valid, ptr_m, ptr_n, in_a, in_b}, snap);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({nm, ":valid"}, in_valid[0], 1);
                check({nm, ":lastk"}, in_valid[1], e.lk);
                check({nm, ":in_a"}, in_a, e.a);
                check({nm, ":in_b"}, in_b, e.b);
                check({nm, ":ptr_m"}, ptr_m, e.pm);
                check({nm, ":ptr_n"}, ptr_n, e.pn);
                check({nm, ":busy_run"}, busy, 1);
                check({nm, ":done_run"}, done, 0);
                if (words == 0) begin
                    first_a  = in_a;
                    first_b  = in_b;
                    first_pm = ptr_m;
                    first_pn = ptr_n;
                    first_v  = in_valid;
                end
                words++;
                if (in_valid[1]) lk_cnt++;
                last_a  = in_a;
                last_pm = ptr_m;
                last_pn = ptr_n;
                if (words == stall_at + 1) stall_left = 3;
            end else begin
                check({nm, ":done_pulse"}, done, 1);
                check({nm, ":busy_done"}, busy, 0);
                check({nm, ":vld_done"}, in_valid, 0);
                check({nm, ":word_cnt"}, words, WORDS);
                check({nm, ":lastk_cnt"}, lk_cnt, WORDS / KTILES);
                fin = 1'b1;
            end
        end
        check({nm, ":timeout"}, fin, 1);
        tick(1);
        check({nm, ":done_clear"}, done, 0);
        check({nm, ":busy_idle"}, busy, 0);
        check({nm, ":vld_idle"}, in_valid, 0);
    endtask

    task automatic reset_mid();
        int words = 0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int c = 0; c < 200 && words < 21; c++) begin
            tick(1);
            if (in_valid[0]) words++;
        end
        check("rst_mid:reached", words, 21);
        reset = 1'b1;
        tick(1);
        check("rst_mid:busy", busy, 0);
        check("rst_mid:done", done, 0);
        check("rst_mid:vld", in_valid, 0);
        check("rst_mid:in_a", in_a, 0);
        check("rst_mid:in_b", in_b, 0);
        check("rst_mid:ptrs", {ptr_m, ptr_n}, 0);
        reset = 1'b0;
        tick(1);
        check("rst_mid:stay_idle", busy, 0);
    endtask

    task automatic set_plan();
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) ma[i][k] = 8'(i * 16 + k);
        for (int k = 0; k < K; k++) for (int n = 0; n < N; n++) mb[k][n] = 8'(k * 16 + n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        a_we   = 1'b0;
        b_we   = 1'b0;
        start  = 1'b0;
        a_row  = '0;
        b_row  = '0;
        a_data = '0;
        b_data = '0;
        repeat (3) tick(1);
        reset = 1'b0;
        tick(0);
        check("reset:busy", busy, 0);
        check("reset:done", done, 0);
        check("reset:vld", in_valid, 0);
        check("reset:in_a", in_a, 0);
        check("reset:in_b", in_b, 0);
        check("reset:ptrs", {ptr_m, ptr_n}, 0);

        // start while enable is low must not begin a sweep
        start = 1'b1;
        tick(0);
        start = 1'b0;
        tick(1);
        check("start_no_en:busy", busy, 0);

        set_plan();
        load_all();
        run_sweep("plan", 0, -1, 1'b0);
        check("plan:first_pm", first_pm, 0);
        check("plan:first_pn", first_pn, 0);
        check("plan:first_v", first_v, 2'b01);
        check("plan:first_a_g1j2", first_a[(1*NM+2)*DW +: DW], 8'h12);
        check("plan:first_b_u3j1", first_b[(3*NM+1)*DW +: DW], 8'h13);
        check("plan:last_pm", last_pm, 3);
        check("plan:last_pn", last_pn, 3);
        check("plan:last_a_00", last_a[DW-1:0], 8'hCC);

        run_sweep("stall", 0, 10, 1'b0);
        run_sweep("poke", 0, -1, 1'b1);

        reset_mid();
        // stores are cleared by reset: an unreloaded sweep is all zero
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) ma[i][k] = 8'h00;
        for (int k = 0; k < K; k++) for (int n = 0; n < N; n++) mb[k][n] = 8'h00;
        run_sweep("cleared", 0, -1, 1'b0);
        set_plan();
        load_all();
        run_sweep("reload", 0, -1, 1'b0);
        check("reload:first_a_g1j2", first_a[(1*NM+2)*DW +: DW], 8'h12);

        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) ma[i][k] = (i == k) ? 8'h01 : 8'h00;
        for (int k = 0; k < K; k++) for (int n = 0; n < N; n++) mb[k][n] = 8'h7F;
        load_all();
        run_sweep("ident", 0, -1, 1'b0);
        check("ident:diag00", first_a[(0*NM+0)*DW +: DW], 8'h01);
        check("ident:diag11", first_a[(1*NM+1)*DW +: DW], 8'h01);
        check("ident:off01", first_a[(0*NM+1)*DW +: DW], 8'h00);
        check("ident:b_lane", first_b[(2*NM+3)*DW +: DW], 8'h7F);
        check("ident:last_diag", last_a[DW-1:0], 8'h01);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) ma[i][k] = 8'($urandom);
            for (int k = 0; k < K; k++) for (int n = 0; n < N; n++) mb[k][n] = 8'($urandom);
            load_all();
            run_sweep("rand", 30, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mm_tile_feeder.md
Name: mm_tile_feeder

Overview:
- Transmit side of the mm_unit tile interface.
- Holds one A matrix (M×K, int8) and one B matrix (K×N, int8), each loaded row by row.
- On start, streams every (m-tile, n-tile, k-tile) triple as packed in_a/in_b/ptr_m/ptr_n/in_valid words. Issue rate is one tile per enabled cycle, with the same enable stall semantics as the consumer.
- Sits between the operand load path and mm_unit.

Parameters:
- M, 16, rows of A and C
- K, 16, shared dimension
- N, 16, columns of B and C
- N_GROUP, 4, m-tile height (rows of A per tile)
- N_MUL, 4, k-tile depth
- N_UNIT, 4, n-tile width (columns of B per tile)
- DW_MUL, 8, operand element width
- DW_INT, 8, pointer/index width
- DW_CORE_IN_A, DW_MUL*N_MUL*N_GROUP, packed A-tile width
- DW_CORE_IN_B, DW_MUL*N_MUL*N_UNIT, packed B-tile width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  advance; when low, all state and outputs hold (matches consumer stall)
- a_we  in  1  write one A row
- a_row  in  DW_INT  A row index, 0..M-1
- a_data  in  DW_MUL*K  A row; element k at [k*DW_MUL +: DW_MUL]
- b_we  in  1  write one B row
- b_row  in  DW_INT  B row index, 0..K-1
- b_data  in  DW_MUL*N  B row; element n at [n*DW_MUL +: DW_MUL]
- start  in  1  single-cycle pulse; begin a tile sweep
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse after the last tile is issued
- ptr_m  out  DW_INT  m-tile index of the current word
- ptr_n  out  DW_INT  n-tile index of the current word
- in_a  out  DW_CORE_IN_A  packed A tile (signed)
- in_b  out  DW_CORE_IN_B  packed B tile (signed)
- in_valid  out  2  [0] tile valid; [1] last k-tile of this (ptr_m, ptr_n)

Behaviour:
- Reset: FSM returns to IDLE from any state, including mid-sweep. All outputs are 0, counters are 0, and both matrix stores are cleared to 0.
- Loads:
  - a_we/b_we write on the clock edge only in IDLE; they are ignored while busy.
  - Out-of-range row indices are ignored.
  - a_we and b_we in the same cycle both take effect.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start&enable. The counters mt, nt, kt are cleared to 0; busy=1 from the next cycle.
  - RUN: each enabled cycle registers one tile word, then increments the counters. Loop order is kt innermost, nt middle, mt outermost.
  - Counter limits: kt wraps at K/N_MUL, nt at N/N_UNIT, mt at M/N_GROUP.
  - After issuing the word with mt, nt and kt all at their maxima, go to DONE.
  - DONE: done=1, busy=0 and in_valid=0 for one enabled cycle, then IDLE.
  - start outside IDLE is ignored.
- Output word for tile (mt, nt, kt):
  - Registered; it appears one enabled cycle after the counters hold those values.
  - The first word appears the cycle after RUN is entered.
  - in_a[(g*N_MUL+j)*DW_MUL +: DW_MUL] = A[mt*N_GROUP+g][kt*N_MUL+j].
  - in_b[(u*N_MUL+j)*DW_MUL +: DW_MUL] = B[kt*N_MUL+j][nt*N_UNIT+u].
  - ptr_m = mt, ptr_n = nt.
  - in_valid = {kt==K/N_MUL-1, 1'b1}.
- Sweep length: with defaults, 64 words over 64 enabled cycles, plus 1 DONE cycle.
- enable low: counters, FSM and every output register hold their value. A held word is not re-counted.
- Values are raw bit copies; no arithmetic.
- Divisibility: M, K and N must be multiples of their tile sizes. This is checked by a simulation-time assertion only.

Decomposition:
- Shared package holds: derived tile counts (M/N_GROUP, N/N_UNIT, K/N_MUL), the in_valid bit positions (VLD, LASTK), and the FSM state encoding.
- One sub-module: mm_tile_counter. This is the three-level nested wrap counter with enable, producing mt, nt, kt, a last flag and a last-k flag.
- Tile gather/packing stays in the top module.

Test Plan:
- A[i][k]=i*16+k, B[k][n]=k*16+n, start → first word is ptr_m=0, ptr_n=0, in_valid=01, in_a lane (g=1, j=2) = 0x12, in_b lane (u=3, j=1) = 0x13.
- Same load, full sweep → exactly 64 words with in_valid[0]=1. in_valid[1]=1 on every 4th word. Last word is ptr_m=3, ptr_n=3, in_a lane (0,0)=0xCC. done pulses once, on the following cycle.
- Deassert enable for 3 cycles at word 10 → outputs are frozen for those 3 cycles. The sequence then resumes at word 11; total remains 64 words.
- a_we during RUN with a_data all 0xFF → ignored; the swept values are unchanged. A second start while busy → ignored, with no restart.
- Assert reset at word 20 → next cycle busy=0, in_valid=00, outputs 0. A subsequent start after reloading produces word 0 again.
- A=identity, B=all 0x7F (signed) → diagonal tile lanes = 0x01, off-diagonal lanes = 0x00, all in_b lanes = 0x7F.
